// File: rtl/wb_store_buffer.sv
// Posted-store FIFO between writeback and the dcache write port.
// Drains in order on In_write_ready, flags loads that overlap pending stores.
module wb_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              WB_st_v,
    input  logic [ADDR_W-1:0] WB_st_address,
    input  logic [DATA_W-1:0] WB_st_data,
    input  logic [1:0]        WB_st_size,
    output logic              sb_wb_stall,
    output logic              DC_write,
    output logic [ADDR_W-1:0] DC_write_address,
    output logic [DATA_W-1:0] DC_write_data,
    output logic [1:0]        DC_write_size,
    input  logic              In_write_ready,
    input  logic              LD_check_v,
    input  logic [ADDR_W-1:0] LD_address,
    output logic              sb_ld_conflict,
    input  logic              drain_req,
    output logic              sb_drained,
    output logic [PTR_W:0]    sb_count
);
    // state | meaning
    // IDLE  | nothing presented to the dcache
    // ISSUE | head entry presented on DC_write_*, waiting for In_write_ready
    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [1:0]        size_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [PTR_W:0]    count_q, count_d;
    logic              full, push, pop, hit;
    logic              in_unused;

    // drain_req only matters to the requester; the buffer drains whenever it holds stores
    assign in_unused = drain_req ^ (^LD_address[2:0]);

    assign full = (count_q == (PTR_W+1)'(DEPTH));
    assign push = WB_st_v & ~full;
    assign pop  = (state_q == ISSUE) & In_write_ready;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_q != '0) state_d = ISSUE;
            ISSUE:   if (pop && count_d == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= IDLE;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                size_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            // a push never targets the head slot on a pop cycle: that needs a full buffer
            if (push) begin
                addr_q[tail_q]  <= WB_st_address;
                data_q[tail_q]  <= WB_st_data;
                size_q[tail_q]  <= WB_st_size;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_W'(1);
            end
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i][ADDR_W-1:3] == LD_address[ADDR_W-1:3])) begin
                hit = 1'b1;
            end
        end
    end

    assign sb_ld_conflict   = LD_check_v & hit;
    assign sb_wb_stall      = WB_st_v & full;
    assign DC_write         = (state_q == ISSUE);
    assign DC_write_address = addr_q[head_q];
    assign DC_write_data    = data_q[head_q];
    assign DC_write_size    = size_q[head_q];
    assign sb_drained       = (count_q == '0) && (state_q == IDLE);
    assign sb_count         = count_q;

endmodule

// File: doc/wb_store_buffer.md
Name: wb_store_buffer

Overview:
- Posted-store buffer between the writeback stage and the dcache write port.
- Writeback pushes validated stores (address, 64-bit data, size) in one cycle instead of stalling on the dcache write handshake.
- The buffer drains in FIFO order to the dcache using the In_write_ready handshake.
- It also flags younger loads that hit a pending store, and supports a drain request used by halt and serializing uops.

Parameters:
- DEPTH, 4, number of store entries; power of two, 2..8
- PTR_W, 2, log2(DEPTH)
- ADDR_W, 32, store address width
- DATA_W, 64, store data width

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- CLR  in  1  reset, asynchronous, active-low
- WB_st_v  in  1  writeback store push request (already validated)
- WB_st_address  in  ADDR_W  store address
- WB_st_data  in  DATA_W  store data
- WB_st_size  in  2  store datasize code, passed through unchanged
- sb_wb_stall  out  1  push rejected this cycle; writeback must hold
- DC_write  out  1  dcache write request
- DC_write_address  out  ADDR_W  head entry address
- DC_write_data  out  DATA_W  head entry data
- DC_write_size  out  2  head entry size
- In_write_ready  in  1  dcache accepts the write on this edge
- LD_check_v  in  1  load address check valid
- LD_address  in  ADDR_W  load address to check
- sb_ld_conflict  out  1  load overlaps a pending store
- drain_req  in  1  request to empty the buffer (level)
- sb_drained  out  1  buffer empty and no write outstanding
- sb_count  out  PTR_W+1  number of occupied entries

Behaviour:
- Storage: DEPTH entries of {address, data, size, valid}, plus head pointer, tail pointer and count. Pointers wrap modulo DEPTH.
- Reset (CLR low, asynchronous):
  - Pointers, count and all valid bits go to 0; FSM goes to IDLE.
  - Outputs: DC_write=0, DC_write_address/data/size=0, sb_wb_stall=0, sb_ld_conflict=0, sb_drained=1, sb_count=0.
  - Reset mid-handshake discards all entries, including the one being written; the dcache must treat CLR as cancelling the request.
- Push:
  - Accepted on the edge when WB_st_v=1 and count<DEPTH (count as registered at the start of the cycle). The entry is written at tail, tail increments, valid is set.
  - sb_wb_stall = WB_st_v & (count==DEPTH), combinational.
  - If a pop occurs in the same cycle as a full-buffer push, the push is still rejected. Writeback retries the next cycle.
- FSM (2 states):
  - IDLE: DC_write=0. If count>0, go to ISSUE next cycle. The minimum push-to-DC_write latency is 1 cycle.
  - ISSUE: DC_write=1; address/data/size come from the head entry and stay stable until accepted.
    - On an edge with In_write_ready=1: pop the head (clear valid, head+1, count-1). If count after pop >0, stay in ISSUE and present the next entry the following cycle (back-to-back, one write per cycle). Otherwise go to IDLE.
    - On an edge with In_write_ready=0: hold all outputs.
- Simultaneous push and pop when not full: count is unchanged; both pointers advance.
- DC_write_* outputs are driven from head entry registers. While in IDLE they hold their last values; verification ignores them when DC_write=0.
- Load conflict (combinational):
  - sb_ld_conflict = LD_check_v & OR over valid entries of (entry.address[ADDR_W-1:3] == LD_address[ADDR_W-1:3]), i.e. 8-byte granularity.
  - A store being pushed in the same cycle is not compared. It becomes visible on the next cycle.
  - The entry being popped this cycle is still compared.
- Drain:
  - sb_drained = (count==0) & (state==IDLE).
  - drain_req does not block pushes; the requester must stop pushing.
  - drain_req has no effect on the write order.
- sb_count is the registered count.

Test Plan:
- Reset then idle, In_write_ready=1: no pushes -> DC_write=0, sb_drained=1, sb_count=0 for 10 cycles.
- Push 0x00001000/data 0x1122334455667788/size 2'b10 with In_write_ready=1 -> DC_write high exactly 1 cycle after the push edge with matching fields; sb_count goes 1->0; sb_drained=1 two cycles after the push.
- Hold In_write_ready=0 and push 5 stores (addresses 0x100, 0x108, 0x110, 0x118, 0x120):
  - First 4 accepted; 5th sees sb_wb_stall=1 and sb_count=4; DC_write_address holds 0x100.
  - Raise In_write_ready -> writes in order 0x100..0x118 on consecutive cycles; the retried 0x120 is accepted the cycle after the first pop and written last.
- Pending store at 0x2004 with In_write_ready=0:
  - LD_address 0x2000 -> sb_ld_conflict=1.
  - LD_address 0x2008 -> 0.
  - LD_check_v=0 -> 0.
  - After the write is accepted, LD 0x2000 -> 0.
- Wrap-around: 10 pushes with alternating In_write_ready -> all 10 writes emitted in push order, with no loss or duplication across pointer wrap.
- Assert CLR while in ISSUE with 3 entries -> DC_write=0, sb_count=0, sb_drained=1 immediately (before the next clock edge); after release, a new push is written first.
